mmu_nxn: RTL and testbench
==========================

Name: mmu_nxn

Overview:
- Parametrised NxN integer matrix-multiply unit computing C = A x B. Successor to the fixed 2x2 MMU.
- Operands are latched on a start handshake. One rank-1 update (k-slice) is accumulated per cycle over N cycles, then results are narrowed to output width with optional saturation.
- Adds signed mode, saturate/wrap mode, a busy flag, and a one-cycle done pulse.
- Sits between the operand buffers and the result writeback in the accelerator datapath.

Parameters:
- N, 2, matrix dimension; N >= 2.
- DW, 8, element width of A, B and C.
- ACCW, 2*DW+$clog2(N), accumulator width; must hold the full sum without internal overflow.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; accepted only in IDLE.
- signed_mode  input  1  1 = operands and result are two's complement; latched at accept.
- sat_mode  input  1  1 = saturate on narrowing, 0 = wrap (keep low DW bits); latched at accept.
- A_flat  input  N*N*DW  row-major; element (r,c) at bits [(r*N+c)*DW +: DW].
- B_flat  input  N*N*DW  same packing as A_flat.
- C_flat  output  N*N*DW  registered result, same packing.
- busy  output  1  high while in MAC or OUT.
- done  output  1  one-cycle pulse when C_flat updates.

Behaviour:
- Reset (synchronous, dominates all other inputs): state=IDLE, k=0, accumulators=0, C_flat=0, done=0, busy=0.
- Reset asserted mid-operation aborts it. No done pulse follows, and C_flat reads 0 after the reset edge.
- IDLE, start=1:
  - Latch A_flat, B_flat, signed_mode and sat_mode.
  - Clear all accumulators, set k=0, go to MAC.
- IDLE, start=0: hold state; C_flat retains its last value.
- MAC, each cycle:
  - acc[i][j] += ext(A[i][k]) * ext(B[k][j]) for all i,j in 0..N-1.
  - ext = sign-extend if signed_mode, otherwise zero-extend, to ACCW.
  - k increments each cycle. The MAC at k=N-1 transitions to OUT.
- OUT (one cycle):
  - C_flat[i][j] <= narrow(acc[i][j]); done <= 1; go to IDLE.
  - All C elements update on the same edge.
- narrow, wrap (sat_mode=0): acc[DW-1:0].
- narrow, saturate (sat_mode=1):
  - Unsigned: values above 2^DW-1 clamp to 2^DW-1.
  - Signed: clamp to [-2^(DW-1), 2^(DW-1)-1].
- done: high only for the cycle after the OUT edge (state is IDLE again); low in every other cycle.
- busy: high from the edge after accept through the OUT cycle inclusive. It is low in the cycle where done is high.
- Latency: start sampled at edge e0 gives done=1 and valid C_flat after edge e0+N+1. For N=2 that is 3 cycles.
- Throughput:
  - start held high is re-accepted in the done cycle, giving back-to-back jobs every N+2 cycles.
  - start while busy is ignored: not queued, and no operand or mode change.
- Input changes on A_flat, B_flat or the mode inputs after accept have no effect on the running job.

Test Plan:
1. Reset check. Assert rst for 2 cycles with start=1 -> C_flat=0, done=0, busy=0 throughout, and no job starts.
2. Unsigned wrap, N=2.
   - Stimulus: A_flat=0x04030201 ([1,2;3,4]), B_flat=0x08070605 ([5,6;7,8]), one-cycle start.
   - Response: busy=1 for 3 cycles, then done=1 for exactly 1 cycle with C_flat=0x322B1613 ([19,22;43,50]).
3. Unsigned overflow.
   - Stimulus: A all 200 (0xC8C8C8C8), B all 2.
   - sat_mode=0 -> C_flat=0x20202020 (800 mod 256).
   - sat_mode=1 -> C_flat=0xFFFFFFFF.
4. Signed mode.
   - Stimulus: A all -100 (0x9C9C9C9C), B all 100 (0x64646464), signed_mode=1; each element is -20000.
   - sat_mode=1 -> C_flat=0x80808080.
   - sat_mode=0 -> C_flat=0xE0E0E0E0.
5. Handshake.
   - Pulse start again during MAC with different A -> ignored; the result matches the first operands.
   - Hold start high continuously -> a second job is accepted in the done cycle, and done pulses every 4 cycles for N=2.
6. Reset mid-op and N=4.
   - Assert rst in the second MAC cycle -> next cycle busy=0, C_flat=0, and no done afterwards.
   - With N=4, A = identity and B = 0..15 -> C_flat equals B_flat, with done exactly 5 cycles after start.

Source files
------------

// File: rtl/mmu_nxn.sv
// Parametrised NxN integer matrix-multiply unit: C = A x B, one rank-1 k-slice per cycle,
// with signed/unsigned operands and saturating or wrapping narrowing of the results.
module mmu_nxn #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int ACCW = 2*DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              sat_mode,
    input  logic [N*N*DW-1:0] A_flat,
    input  logic [N*N*DW-1:0] B_flat,
    output logic [N*N*DW-1:0] C_flat,
    output logic              busy,
    output logic              done
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [ACCW-1:0] UMAX = {{(ACCW-DW){1'b0}}, {DW{1'b1}}};
    localparam logic [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t            state_q;
    logic [KW-1:0]     k_q;
    logic [N*N*DW-1:0] a_q, b_q, c_q, c_d;
    logic              signed_q, sat_q, busy_q, done_q;
    logic [ACCW-1:0]   acc_q [N*N];
    logic [ACCW-1:0]   acc_d [N*N];

    function automatic logic [ACCW-1:0] ext(input logic [DW-1:0] v, input logic sgn);
        return sgn ? {{(ACCW-DW){v[DW-1]}}, v} : {{(ACCW-DW){1'b0}}, v};
    endfunction

    function automatic logic [DW-1:0] narrow(input logic [ACCW-1:0] acc,
                                             input logic sgn, input logic sat);
        logic [DW-1:0] r;
        r = acc[DW-1:0];
        if (sat) begin
            if (sgn) begin
                if ($signed(acc) > $signed(SMAX))      r = SMAX[DW-1:0];
                else if ($signed(acc) < $signed(SMIN)) r = SMIN[DW-1:0];
            end else if (acc > UMAX) begin
                r = UMAX[DW-1:0];
            end
        end
        return r;
    endfunction

    // Products are kept to ACCW bits; modular arithmetic gives the right two's-complement sum.
    always_comb begin
        acc_d = acc_q;
        c_d   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc_d[i*N+j] = acc_q[i*N+j]
                             + ext(a_q[(i*N+int'(k_q))*DW +: DW], signed_q)
                             * ext(b_q[(int'(k_q)*N+j)*DW +: DW], signed_q);
                c_d[(i*N+j)*DW +: DW] = narrow(acc_q[i*N+j], signed_q, sat_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int n = 0; n < N*N; n++) acc_q[n] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= A_flat;
                        b_q      <= B_flat;
                        signed_q <= signed_mode;
                        sat_q    <= sat_mode;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= MAC;
                        for (int n = 0; n < N*N; n++) acc_q[n] <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == KW'(N-1)) begin
                        k_q     <= '0;
                        state_q <= OUT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                OUT: begin
                    c_q     <= c_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C_flat = c_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mmu_nxn.sv
// Directed bench for mmu_nxn: a 2x2 instance for the arithmetic and handshake cases
// and a 4x4 instance for the larger-dimension latency case.
module tb_mmu_nxn;

    logic         clk = 1'b0;
    logic         rst;
    logic         start2, signedMode2, satMode2;
    logic [31:0]  aFlat2, bFlat2, cFlat2;
    logic         busy2, done2;
    logic         start4, signedMode4, satMode4;
    logic [127:0] aFlat4, bFlat4, cFlat4;
    logic         busy4, done4;

    int checkCount = 0;
    int errorCount = 0;

    mmu_nxn #(.N(2), .DW(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(signedMode2), .sat_mode(satMode2),
        .A_flat(aFlat2), .B_flat(bFlat2), .C_flat(cFlat2), .busy(busy2), .done(done2)
    );

    mmu_nxn #(.N(4), .DW(8)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(signedMode4), .sat_mode(satMode4),
        .A_flat(aFlat4), .B_flat(bFlat4), .C_flat(cFlat4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are stable and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle start on the 2x2 unit, then check busy/done timing and the result.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn, input logic sat, input logic [31:0] expC);
        aFlat2 = a; bFlat2 = b; signedMode2 = sgn; satMode2 = sat;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput({tag, " busy"}, busy2, 1'b1);
            checkOutput({tag, " no early done"}, done2, 1'b0);
            step();
        end
        checkOutput({tag, " done"}, done2, 1'b1);
        checkOutput({tag, " busy in done cycle"}, busy2, 1'b0);
        checkOutput({tag, " C"}, cFlat2, expC);
        step();
        checkOutput({tag, " done single"}, done2, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start2 = 1'b1; signedMode2 = 1'b0; satMode2 = 1'b0;
        aFlat2 = 32'h04030201; bFlat2 = 32'h08070605;
        start4 = 1'b0; signedMode4 = 1'b0; satMode4 = 1'b0;
        aFlat4 = '0; bFlat4 = '0;

        // Reset held for two cycles with start asserted
        for (int c = 0; c < 2; c++) begin
            step();
            checkOutput("reset C", cFlat2, 32'h0);
            checkOutput("reset done", done2, 1'b0);
            checkOutput("reset busy", busy2, 1'b0);
        end
        checkOutput("reset C4", cFlat4, 128'h0);
        rst = 1'b0;
        start2 = 1'b0;
        step();
        checkOutput("no job after reset", busy2, 1'b0);

        applyStimulus("uwrap", 32'h04030201, 32'h08070605, 1'b0, 1'b0, 32'h322B1613);
        applyStimulus("uovf wrap", 32'hC8C8C8C8, 32'h02020202, 1'b0, 1'b0, 32'h20202020);
        applyStimulus("uovf sat", 32'hC8C8C8C8, 32'h02020202, 1'b0, 1'b1, 32'hFFFFFFFF);
        applyStimulus("signed sat", 32'h9C9C9C9C, 32'h64646464, 1'b1, 1'b1, 32'h80808080);
        applyStimulus("signed wrap", 32'h9C9C9C9C, 32'h64646464, 1'b1, 1'b0, 32'hE0E0E0E0);

        // Start during MAC with new operands and modes must be ignored
        aFlat2 = 32'h04030201; bFlat2 = 32'h08070605; signedMode2 = 1'b0; satMode2 = 1'b0;
        start2 = 1'b1;
        step();
        aFlat2 = 32'hFFFFFFFF; signedMode2 = 1'b1; satMode2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        step();
        checkOutput("ignore start done", done2, 1'b1);
        checkOutput("ignore start C", cFlat2, 32'h322B1613);
        step();
        checkOutput("ignore start not queued", busy2, 1'b0);

        // Start held high: re-accepted in the done cycle, done every 4 cycles
        aFlat2 = 32'h04030201; bFlat2 = 32'h08070605; signedMode2 = 1'b0; satMode2 = 1'b0;
        start2 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checkOutput("b2b done pattern", done2, (c == 3 || c == 7) ? 1'b1 : 1'b0);
            if (c == 3) begin
                checkOutput("b2b first C", cFlat2, 32'h322B1613);
                aFlat2 = 32'h01000001;
            end
            if (c == 7) begin
                checkOutput("b2b second C", cFlat2, 32'h08070605);
                start2 = 1'b0;
            end
        end
        step();
        checkOutput("b2b stops", busy2, 1'b0);

        // Reset in the second MAC cycle aborts the job
        aFlat2 = 32'hC8C8C8C8; bFlat2 = 32'h02020202;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort busy", busy2, 1'b0);
        checkOutput("abort C", cFlat2, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("abort no done", done2, 1'b0);
        end

        // 4x4: identity times 0..15 yields B, done exactly 5 cycles after start
        aFlat4 = 128'h01000000_00010000_00000100_00000001;
        bFlat4 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            checkOutput("n4 done timing", done4, (c == 5) ? 1'b1 : 1'b0);
            checkOutput("n4 busy", busy4, (c == 5) ? 1'b0 : 1'b1);
        end
        checkOutput("n4 C", cFlat4, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
